// File: rtl/vrp_rr_two_port_sched_if.sv
// Requester-side and output-side handshake bundle for the two-port round-robin scheduler.
// The scheduler connects through the slave modport; whatever feeds and drains it uses master.
interface vrp_rr_two_port_sched_if #(
  parameter int N         = 10,
  parameter int PLD_WIDTH = 8
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]         req_vld;
  logic [N-1:0]         req_rdy;
  logic [PLD_WIDTH-1:0] req_pld [N-1:0];
  logic [1:0]           out_vld;
  logic [1:0]           out_rdy;
  logic [PLD_WIDTH-1:0] out_pld [1:0];
  logic [IDX_W-1:0]     out_idx [1:0];

  modport master (
    output req_vld, req_pld, out_rdy,
    input  req_rdy, out_vld, out_pld, out_idx
  );

  modport slave (
    input  req_vld, req_pld, out_rdy,
    output req_rdy, out_vld, out_pld, out_idx
  );
endinterface

// File: rtl/vrp_rr_two_port_sched.sv
// Round-robin scheduler granting up to two of N requesters per cycle into two
// registered output slots; the pointer advances past the last requester loaded.
module vrp_rr_two_port_sched #(
  parameter int N          = 10,
  parameter int PLD_WIDTH  = 8,
  parameter int RD_REQ_NUM = 5,
  parameter int WR_REQ_NUM = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  vrp_rr_two_port_sched_if.slave    bus
);
  localparam int REQ_NUM = RD_REQ_NUM + WR_REQ_NUM;
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;

  generate
    if (N != REQ_NUM) begin : g_cfg_err
      $error("vrp_rr_two_port_sched: N must equal RD_REQ_NUM + WR_REQ_NUM");
    end
  endgenerate

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_st_t;

  slot_st_t             slot_st_p1  [1:0];
  slot_st_t             slot_st_nxt [1:0];
  logic [PLD_WIDTH-1:0] slot_pld_p1 [1:0];
  logic [IDX_W-1:0]     slot_idx_p1 [1:0];
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     rr_ptr_nxt;

  logic [IDX_W-1:0]     cand_a;
  logic [IDX_W-1:0]     cand_b;
  logic                 cand_a_vld;
  logic                 cand_b_vld;
  logic [1:0]           ldable;
  logic [1:0]           load;
  logic [IDX_W-1:0]     load_idx [1:0];
  logic [N-1:0]         gnt;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == N - 1) ? '0 : i + 1'b1;
  endfunction

  // ---- stage p0: circular scan from rr_ptr for the first two active requesters
  always_comb begin : p_scan
    int idx;
    idx        = 0;
    cand_a     = '0;
    cand_b     = '0;
    cand_a_vld = 1'b0;
    cand_b_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (bus.req_vld[IDX_W'(idx)]) begin
        if (!cand_a_vld) begin
          cand_a_vld = 1'b1;
          cand_a     = IDX_W'(idx);
        end else if (!cand_b_vld) begin
          cand_b_vld = 1'b1;
          cand_b     = IDX_W'(idx);
        end
      end
    end
  end

  // A always goes to the lowest loadable slot; B only when both slots can take data.
  always_comb begin : p_assign
    ldable[0]   = (slot_st_p1[0] == SLOT_EMPTY) | bus.out_rdy[0];
    ldable[1]   = (slot_st_p1[1] == SLOT_EMPTY) | bus.out_rdy[1];
    load        = 2'b00;
    load_idx[0] = cand_a;
    load_idx[1] = cand_a;
    if (ldable == 2'b11) begin
      load[0]     = cand_a_vld;
      load[1]     = cand_b_vld;
      load_idx[1] = cand_b;
    end else if (ldable[0]) begin
      load[0] = cand_a_vld;
    end else if (ldable[1]) begin
      load[1] = cand_a_vld;
    end

    gnt = '0;
    for (int p = 0; p < 2; p++) begin
      if (load[p]) gnt[load_idx[p]] = 1'b1;
    end

    rr_ptr_nxt = rr_ptr;
    if (load[1]) begin
      rr_ptr_nxt = ptr_inc(load_idx[1]);
    end else if (load[0]) begin
      rr_ptr_nxt = ptr_inc(load_idx[0]);
    end
  end

  always_comb begin : p_slot_nxt
    for (int p = 0; p < 2; p++) begin
      slot_st_nxt[p] = slot_st_p1[p];
      case (slot_st_p1[p])
        SLOT_EMPTY: if (load[p]) slot_st_nxt[p] = SLOT_FULL;
        SLOT_FULL:  if (!load[p] && bus.out_rdy[p]) slot_st_nxt[p] = SLOT_EMPTY;
      endcase
    end
  end

  // ---- stage p1: registered output slots and pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_st_p1[0] <= SLOT_EMPTY;
      slot_st_p1[1] <= SLOT_EMPTY;
      rr_ptr        <= '0;
    end else begin
      slot_st_p1 <= slot_st_nxt;
      rr_ptr     <= rr_ptr_nxt;
    end
  end

  // Slot contents are cleared on reset so a discarded transfer never reappears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        slot_pld_p1[p] <= '0;
        slot_idx_p1[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (load[p]) begin
          slot_pld_p1[p] <= bus.req_pld[load_idx[p]];
          slot_idx_p1[p] <= load_idx[p];
        end
      end
    end
  end

  assign bus.req_rdy = rst_n ? gnt : '0;
  assign bus.out_vld = {slot_st_p1[1] == SLOT_FULL, slot_st_p1[0] == SLOT_FULL};
  assign bus.out_pld = slot_pld_p1;
  assign bus.out_idx = slot_idx_p1;

endmodule

// File: tb/tb_vrp_rr_two_port_sched.sv
// Self-checking bench for vrp_rr_two_port_sched: directed scenarios plus a randomized run
// against a queue-based reference of the scheduling rules, a delivery scoreboard and a wait bound.
`timescale 1ns/1ps
module tb_vrp_rr_two_port_sched;
  localparam int N           = 10;
  localparam int W           = 8;
  localparam int FAIR_BOUND  = (N + 1) / 2;
  localparam int RAND_CYCLES = 10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vrp_rr_two_port_sched_if #(.N(N), .PLD_WIDTH(W)) bus ();

  vrp_rr_two_port_sched #(
    .N(N), .PLD_WIDTH(W), .RD_REQ_NUM(5), .WR_REQ_NUM(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int         idx;
    logic [W-1:0] pld;
  } item_t;

  int           n_checks = 0;
  int           n_fails  = 0;
  bit           m_full [2];
  logic [W-1:0] m_pld  [2];
  int           m_idx  [2];
  int           m_ptr;
  logic [W-1:0] pld_hold [N];
  logic [1:0]   cur_ordy;
  bit           g_ok  [2];
  int           g_req [2];
  logic [W-1:0] g_pld [2];
  int           g_last;
  logic [N-1:0] g_vec;
  item_t        sb_q [$];
  int           wait_cnt [N];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_full[p] = 1'b0;
      m_pld[p]  = '0;
      m_idx[p]  = 0;
      g_ok[p]   = 1'b0;
    end
    m_ptr  = 0;
    g_last = -1;
    g_vec  = '0;
    sb_q.delete();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // Present inputs, predict this cycle's grants from the rules, compare everything visible.
  task automatic drive_and_check(input logic [N-1:0] vld, input logic [1:0] ordy);
    int           act_q  [$];
    int           slot_q [$];
    logic [N-1:0] exp_rdy;
    bit           found;
    bus.req_vld = vld;
    bus.out_rdy = ordy;
    cur_ordy    = ordy;
    for (int i = 0; i < N; i++) bus.req_pld[i] = pld_hold[i];
    #1;
    for (int k = 0; k < N; k++) begin
      if (vld[(m_ptr + k) % N]) act_q.push_back((m_ptr + k) % N);
    end
    for (int p = 0; p < 2; p++) begin
      g_ok[p] = 1'b0;
      if (!m_full[p] || ordy[p]) slot_q.push_back(p);
    end
    exp_rdy = '0;
    g_last  = -1;
    for (int g = 0; g < slot_q.size() && g < act_q.size(); g++) begin
      g_ok[slot_q[g]]  = 1'b1;
      g_req[slot_q[g]] = act_q[g];
      g_pld[slot_q[g]] = pld_hold[act_q[g]];
      exp_rdy[act_q[g]] = 1'b1;
      g_last = act_q[g];
    end
    g_vec = exp_rdy;

    check_val("out_vld", bus.out_vld, {m_full[1], m_full[0]});
    for (int p = 0; p < 2; p++) begin
      if (m_full[p]) begin
        check_val($sformatf("out_pld%0d", p), bus.out_pld[p], m_pld[p]);
        check_val($sformatf("out_idx%0d", p), bus.out_idx[p], m_idx[p]);
      end
    end
    check_val("req_rdy", bus.req_rdy, exp_rdy);
    check_val("rr_ptr", dut.rr_ptr, m_ptr);

    for (int p = 0; p < 2; p++) begin
      if (bus.out_vld[p] && ordy[p]) begin
        found = 1'b0;
        for (int j = 0; j < sb_q.size(); j++) begin
          if (!found && sb_q[j].idx == int'(bus.out_idx[p]) && sb_q[j].pld == bus.out_pld[p]) begin
            sb_q.delete(j);
            found = 1'b1;
          end
        end
        check_val("sb_deliver", found, 1'b1);
      end
    end

    for (int i = 0; i < N; i++) begin
      if (vld[i] && ordy == 2'b11) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (bus.req_rdy[i]) begin
        check_val($sformatf("fair_wait%0d", i), (wait_cnt[i] > FAIR_BOUND), 1'b0);
        wait_cnt[i] = 0;
      end
    end
  endtask

  task automatic advance();
    item_t it;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (g_ok[p]) begin
        m_full[p] = 1'b1;
        m_pld[p]  = g_pld[p];
        m_idx[p]  = g_req[p];
        it.idx = g_req[p];
        it.pld = g_pld[p];
        sb_q.push_back(it);
        pld_hold[g_req[p]] = W'($urandom);
      end else if (m_full[p] && cur_ordy[p]) begin
        m_full[p] = 1'b0;
      end
    end
    if (g_last >= 0) m_ptr = (g_last + 1) % N;
  endtask

  task automatic pulse_reset();
    bus.req_vld = '1;
    bus.out_rdy = 2'b11;
    rst_n = 1'b0;
    #1;
    check_val("rst_out_vld", bus.out_vld, 2'b00);
    check_val("rst_req_rdy", bus.req_rdy, '0);
    check_val("rst_idx0", bus.out_idx[0], 0);
    check_val("rst_idx1", bus.out_idx[1], 0);
    check_val("rst_pld0", bus.out_pld[0], 0);
    check_val("rst_pld1", bus.out_pld[1], 0);
    check_val("rst_ptr", dut.rr_ptr, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rv;
    logic [1:0]   ro;
    rst_n       = 1'b1;
    bus.req_vld = '0;
    bus.out_rdy = 2'b00;
    for (int i = 0; i < N; i++) begin
      pld_hold[i]    = W'($urandom);
      bus.req_pld[i] = '0;
    end
    cur_ordy = 2'b00;
    model_reset();
    #2;
    pulse_reset();

    // All requesting, both ports draining: pairs granted, pointer 0,2,4,6 then 8.
    for (int c = 0; c < 4; c++) begin
      drive_and_check('1, 2'b11);
      check_val("basic_rdy", bus.req_rdy, 32'h3 << (2 * c));
      check_val("basic_ptr", dut.rr_ptr, 2 * c);
      if (c > 0) begin
        check_val("basic_idx0", bus.out_idx[0], 2 * c - 2);
        check_val("basic_idx1", bus.out_idx[1], 2 * c - 1);
      end
      advance();
    end
    drive_and_check(10'h301, 2'b11);
    check_val("wrap_rdy", bus.req_rdy, 10'h300);
    check_val("wrap_ptr8", dut.rr_ptr, 8);
    advance();
    drive_and_check(10'h301, 2'b11);
    check_val("wrap_idx0", bus.out_idx[0], 8);
    check_val("wrap_idx1", bus.out_idx[1], 9);
    check_val("wrap_ptr0", dut.rr_ptr, 0);
    check_val("wrap_next", bus.req_rdy, 10'h101);
    advance();

    // Stall with both slots full, then release only port 0.
    pulse_reset();
    pld_hold[0] = 8'hA5;
    drive_and_check(10'h003, 2'b11);
    advance();
    for (int c = 0; c < 5; c++) begin
      drive_and_check('1, 2'b00);
      check_val("stall_pld0", bus.out_pld[0], 8'hA5);
      check_val("stall_rdy", bus.req_rdy, '0);
      advance();
    end
    drive_and_check('1, 2'b01);
    check_val("unstall_one", $countones(bus.req_rdy), 1);
    advance();
    drive_and_check('1, 2'b00);
    check_val("no_bubble", bus.out_vld, 2'b11);
    check_val("reload_idx", bus.out_idx[0], 2);

    // Reset pulse in the middle of a stalled cycle.
    #2;
    pulse_reset();

    drive_and_check(10'h020, 2'b11);
    advance();
    drive_and_check('0, 2'b00);
    check_val("single_vld", bus.out_vld, 2'b01);
    check_val("single_idx", bus.out_idx[0], 5);
    check_val("single_ptr", dut.rr_ptr, 6);
    advance();

    // Randomized traffic: requests tend to stay up until granted.
    pulse_reset();
    rv = '0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rv[i] && !g_vec[i]) rv[i] = ($urandom_range(0, 9) != 0);
        else                    rv[i] = ($urandom_range(0, 2) == 0);
      end
      ro = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      drive_and_check(rv, ro);
      advance();
    end
    drive_and_check('0, 2'b00);
    check_val("sb_left", sb_q.size(), int'(m_full[0]) + int'(m_full[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
